// File: rtl/fmap_replay_buffer.sv
// Ping-pong capture buffer between layer 1 and layer 2: stores one feature map per bank
// and replays it NUM_PASSES times over a valid/ready handshake while the other bank fills.
module fmap_replay_buffer #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned MAP_DIM    = 14,
    parameter int unsigned NUM_PASSES = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          data_valid_in,
    input  logic signed [DATA_W-1:0]      pixel_in,
    input  logic                          layer_done_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [DATA_W-1:0]      pixel_out,
    output logic                          out_first,
    output logic                          out_last,
    output logic [$clog2(NUM_PASSES)-1:0] pass_idx,
    output logic                          frame_done,
    output logic [1:0]                    banks_full,
    output logic                          in_overflow,
    output logic                          short_frame
);
    localparam int unsigned Frame = MAP_DIM * MAP_DIM;
    localparam int unsigned PtrW  = $clog2(Frame);
    localparam int unsigned PassW = $clog2(NUM_PASSES);
    localparam logic [PtrW-1:0]  LastPtr  = PtrW'(Frame - 1);
    localparam logic [PassW-1:0] LastPass = PassW'(NUM_PASSES - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StStream} state_e;

    logic [DATA_W-1:0] mem_q [2][Frame];

    state_e            state_q, state_d;
    logic [1:0]        full_q, full_d, set_full, clr_full;
    logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_addr;
    logic [PassW-1:0]  pass_q, pass_d;
    logic              ovf_q, ovf_d, short_q, short_d;
    logic [DATA_W-1:0] pix_q;
    logic              first_q, last_q, done_q;
    logic              wr_en, wr_last, rd_en, hs, rd_last, frame_end;

    // Write side: no backpressure, so a pixel aimed at a full bank is simply dropped.
    assign wr_en   = data_valid_in && !full_q[wr_bank_q];
    assign wr_last = wr_en && (wr_ptr_q == LastPtr);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        wr_bank_d = wr_bank_q;
        set_full  = 2'b00;
        ovf_d     = ovf_q | (data_valid_in & full_q[wr_bank_q]);
        short_d   = short_q;
        if (wr_last) begin
            wr_ptr_d  = '0;
            wr_bank_d = ~wr_bank_q;
            set_full  = wr_bank_q ? 2'b10 : 2'b01;
        end else if (layer_done_in && (wr_ptr_q != '0)) begin
            wr_ptr_d = '0;
            short_d  = 1'b1;
        end else if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
    end

    assign hs        = (state_q == StStream) && out_ready;
    assign rd_last   = hs && (rd_ptr_q == LastPtr);
    assign frame_end = rd_last && (pass_q == LastPass);

    // Read side: rd_ptr_q is the address of the pixel currently presented on pixel_out.
    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        rd_bank_d = rd_bank_q;
        pass_d    = pass_q;
        clr_full  = 2'b00;
        rd_en     = 1'b0;
        rd_addr   = '0;
        case (state_q)
            StIdle: begin
                if (full_q[rd_bank_q]) state_d = StLoad;
            end
            StLoad: begin
                rd_en   = 1'b1;
                state_d = StStream;
            end
            StStream: begin
                if (hs) begin
                    if (rd_last) begin
                        rd_ptr_d = '0;
                        if (frame_end) begin
                            pass_d    = '0;
                            clr_full  = rd_bank_q ? 2'b10 : 2'b01;
                            rd_bank_d = ~rd_bank_q;
                            state_d   = full_q[~rd_bank_q] ? StLoad : StIdle;
                        end else begin
                            pass_d = pass_q + 1'b1;
                            rd_en  = 1'b1;
                        end
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        rd_en    = 1'b1;
                        rd_addr  = rd_ptr_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        full_d = (full_q & ~clr_full) | set_full;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_bank_q][wr_ptr_q] <= pixel_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pass_q    <= '0;
            ovf_q     <= 1'b0;
            short_q   <= 1'b0;
            pix_q     <= '0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            pass_q    <= pass_d;
            ovf_q     <= ovf_d;
            short_q   <= short_d;
            done_q    <= frame_end;
            if (rd_en) begin
                pix_q   <= mem_q[rd_bank_q][rd_addr];
                first_q <= (rd_addr == '0);
                last_q  <= (rd_addr == LastPtr);
            end
        end
    end

    assign out_valid   = (state_q == StStream);
    assign pixel_out   = pix_q;
    assign out_first   = first_q;
    assign out_last    = last_q;
    assign pass_idx    = pass_q;
    assign frame_done  = done_q;
    assign banks_full  = full_q;
    assign in_overflow = ovf_q;
    assign short_frame = short_q;

endmodule

// File: tb/tb_fmap_replay_buffer.sv
// Directed bench for fmap_replay_buffer: a writer feeds frames, a scoreboard of accepted
// frames predicts every replayed pixel, and directed steps check the corner cases.
module tb_fmap_replay_buffer;
    localparam int Frame  = 196;
    localparam int Passes = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              data_valid_in;
    logic signed [7:0] pixel_in;
    logic              layer_done_in;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] pixel_out;
    logic              out_first;
    logic              out_last;
    logic [3:0]        pass_idx;
    logic              frame_done;
    logic [1:0]        banks_full;
    logic              in_overflow;
    logic              short_frame;

    int vectors     = 0;
    int miscompares = 0;

    // Writer, consumer and scoreboard state.
    int wr_left = 0, wr_base = 0;
    bit wr_push = 1'b0, ld_req = 1'b0;
    int ready_mode = 0;
    int exp_q[$];
    int exp_pix = 0, exp_pass = 0, hs_total = 0;
    bit fd_exp = 1'b0, counting = 1'b0;
    int gap = 0, last_gap = -1;

    fmap_replay_buffer #(.DATA_W(8), .MAP_DIM(14), .NUM_PASSES(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .data_valid_in (data_valid_in),
        .pixel_in      (pixel_in),
        .layer_done_in (layer_done_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .pixel_out     (pixel_out),
        .out_first     (out_first),
        .out_last      (out_last),
        .pass_idx      (pass_idx),
        .frame_done    (frame_done),
        .banks_full    (banks_full),
        .in_overflow   (in_overflow),
        .short_frame   (short_frame)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pix_val(input int base, input int i);
        return 8'((base + i) % 128);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, advance the scoreboard, check outputs.
    task automatic cycle();
        bit hs;
        if (wr_left > 0) begin
            data_valid_in = 1'b1;
            pixel_in      = pix_val(wr_base, Frame - wr_left);
            wr_left--;
            if (wr_left == 0 && wr_push) exp_q.push_back(wr_base);
        end else begin
            data_valid_in = 1'b0;
            pixel_in      = '0;
        end
        layer_done_in = ld_req;
        ld_req        = 1'b0;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        hs = out_valid && out_ready;
        @(posedge clk);
        #1;
        fd_exp = 1'b0;
        if (hs) begin
            hs_total++;
            if (exp_pix == Frame - 1) begin
                exp_pix = 0;
                if (exp_pass == Passes - 1) begin
                    exp_pass = 0;
                    void'(exp_q.pop_front());
                    fd_exp   = 1'b1;
                    counting = 1'b1;
                    gap      = 0;
                end else begin
                    exp_pass++;
                end
            end else begin
                exp_pix++;
            end
        end
        check("frame_done", frame_done, fd_exp);
        if (out_valid) begin
            if (exp_q.size() == 0) check("spurious_valid", out_valid, 1'b0);
            else check("replay", {pixel_out, out_first, out_last, pass_idx},
                       {pix_val(exp_q[0], exp_pix), exp_pix == 0, exp_pix == Frame - 1,
                        4'(exp_pass)});
        end
        if (exp_q.size() > 0 && (exp_pass != 0 || exp_pix != 0))
            check("no_bubble", out_valid, 1'b1);
        if (counting) begin
            if (out_valid) begin
                last_gap = gap;
                counting = 1'b0;
            end else begin
                gap++;
            end
        end
    endtask

    task automatic send(input int base, input bit push);
        wr_base = base;
        wr_push = push;
        wr_left = Frame;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() > 0 || wr_left > 0) && n < budget) begin
            cycle();
            n++;
        end
        cycle();
        check("drained", {out_valid, banks_full}, 3'b000);
    endtask

    initial begin
        int hs_start, n;
        rst = 1'b0; data_valid_in = 1'b0; pixel_in = '0; layer_done_in = 1'b0;
        out_ready = 1'b0;
        #1;
        check("reset_outputs", {out_valid, pixel_out, out_first, out_last, pass_idx, frame_done,
              banks_full, in_overflow, short_frame}, '0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        // Single frame with out_ready held high; first valid two cycles after the full edge.
        ready_mode = 1;
        hs_start   = hs_total;
        send(0, 1'b1);
        repeat (Frame) cycle();
        check("full_after_frame", banks_full, 2'b01);
        check("valid_lat0", out_valid, 1'b0);
        cycle();
        check("valid_lat1", out_valid, 1'b0);
        cycle();
        check("valid_lat2", out_valid, 1'b1);
        drain(5000);
        check("single_hs", hs_total - hs_start, Frame * Passes);

        // Random 50% backpressure.
        ready_mode = 2;
        hs_start   = hs_total;
        send(7, 1'b1);
        drain(20000);
        check("bp_hs", hs_total - hs_start, Frame * Passes);

        // Overlap: frame B captured while A replays; B follows after one bubble.
        ready_mode = 1;
        hs_start   = hs_total;
        send(3, 1'b1);
        repeat (Frame + 200) cycle();
        send(40, 1'b1);
        repeat (Frame) cycle();
        check("overlap_full", banks_full, 2'b11);
        drain(10000);
        check("overlap_gap", last_gap, 1);
        check("overlap_hs", hs_total - hs_start, 2 * Frame * Passes);
        check("overlap_no_ovf", in_overflow, 1'b0);

        // Overflow: three frames with the consumer stalled; the third is dropped entirely.
        ready_mode = 0;
        send(10, 1'b1);
        repeat (Frame) cycle();
        send(20, 1'b1);
        repeat (Frame) cycle();
        send(30, 1'b0);
        repeat (Frame) cycle();
        check("ovf_full", banks_full, 2'b11);
        check("ovf_flag", in_overflow, 1'b1);
        check("ovf_stall_pixel", pixel_out, pix_val(10, 0));
        ready_mode = 1;
        hs_start   = hs_total;
        drain(10000);
        check("ovf_hs", hs_total - hs_start, 2 * Frame * Passes);
        check("ovf_sticky", in_overflow, 1'b1);

        // Short frame: 100 pixels then layer_done; only the following full frame replays.
        check("short_clear", short_frame, 1'b0);
        wr_base = 60; wr_push = 1'b0; wr_left = 100;
        repeat (100) cycle();
        ld_req = 1'b1;
        cycle();
        check("short_flag", short_frame, 1'b1);
        check("short_no_full", banks_full, 2'b00);
        hs_start = hs_total;
        send(60, 1'b1);
        drain(5000);
        check("short_hs", hs_total - hs_start, Frame * Passes);

        // Asynchronous reset in the middle of pass 5.
        send(90, 1'b1);
        n = 0;
        while (!(exp_pass == 5 && exp_pix == 80) && n < 5000) begin
            cycle();
            n++;
        end
        check("mid_pass_idx", pass_idx, 4'd5);
        #2 rst = 1'b0;
        #1;
        check("async_reset", {out_valid, pixel_out, out_first, out_last, pass_idx, frame_done,
              banks_full, in_overflow, short_frame}, '0);
        exp_q.delete();
        exp_pix = 0; exp_pass = 0; fd_exp = 1'b0; counting = 1'b0;
        data_valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        hs_start = hs_total;
        send(100, 1'b1);
        drain(5000);
        check("post_reset_hs", hs_total - hs_start, Frame * Passes);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
